// File: rtl/om_est_pkg.sv
// Shared definitions for the Oerder-Meyr timing-estimate accumulator.
//   SEGMENT_DEF / IN_W_DEF / ACC_W_DEF : default segment length and widths
//   state_t                            : segment controller states
//   PH_*                               : quarter-rate rotation phase encodings
package om_est_pkg;

    localparam int SEGMENT_DEF = 1024;
    localparam int IN_W_DEF    = 25;
    localparam int ACC_W_DEF   = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rotation by e^(-j*pi*n/2): the term lands on re/im with alternating sign.
    localparam logic [1:0] PH_RE_ADD = 2'd0;
    localparam logic [1:0] PH_IM_SUB = 2'd1;
    localparam logic [1:0] PH_RE_SUB = 2'd2;
    localparam logic [1:0] PH_IM_ADD = 2'd3;

endpackage

// File: rtl/om_phase_accum.sv
// Complex accumulator for quarter-rate rotated |x|^2 samples.
//   clk, rst          : clock, synchronous active-high reset
//   clr               : synchronous clear (wins over en)
//   en                : add the current sample's rotated term
//   phase             : rotation phase n[1:0] of the current sample
//   sample            : unsigned |x|^2 sample
//   acc_re / acc_im   : registered accumulator
//   nxt_re / nxt_im   : accumulator value including the current term
module om_phase_accum
    import om_est_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [1:0]              phase,
    input  logic [IN_W-1:0]         sample,
    output logic signed [ACC_W-1:0] acc_re,
    output logic signed [ACC_W-1:0] acc_im,
    output logic signed [ACC_W-1:0] nxt_re,
    output logic signed [ACC_W-1:0] nxt_im
);

    logic signed [ACC_W-1:0] term;

    always_comb begin
        term   = $signed({{(ACC_W-IN_W){1'b0}}, sample});
        nxt_re = acc_re;
        nxt_im = acc_im;
        case (phase)
            PH_RE_ADD: nxt_re = acc_re + term;
            PH_IM_SUB: nxt_im = acc_im - term;
            PH_RE_SUB: nxt_re = acc_re - term;
            PH_IM_ADD: nxt_im = acc_im + term;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (en) begin
            acc_re <= nxt_re;
            acc_im <= nxt_im;
        end
    end

endmodule

// File: rtl/om_segment_ctrl.sv
// Segment sequencer for the Oerder-Meyr quarter-rate timing estimate.
// Accepts |x|^2 samples, accumulates SEGMENT rotated terms and presents one
// complex result per segment on a valid/ready output.
//   clk, rst             : clock, synchronous active-high reset
//   start                : arm a new segment (IDLE only)
//   abort                : abandon the current segment, return to IDLE
//   cfg_continuous       : captured on start; re-arm after every result
//   in_valid/in_sample   : sample stream, accepted when in_valid & in_ready
//   in_ready             : high in ACCUM
//   out_valid/out_ready  : result handshake
//   xm_re / xm_im        : signed result, held until the next segment end
//   busy                 : state != IDLE
//
// state | meaning
// IDLE  | waiting for start, no samples taken
// ACCUM | taking samples, cnt = index within segment
// DONE  | result presented, waiting for out_ready
module om_segment_ctrl
    import om_est_pkg::*;
#(
    parameter int SEGMENT = SEGMENT_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cfg_continuous,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         in_sample,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] xm_re,
    output logic signed [ACC_W-1:0] xm_im,
    output logic                    busy
);

    localparam int CNT_W = $clog2(SEGMENT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEGMENT - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cont_q;
    logic                    out_valid_q;
    logic                    accept, last, acc_clr;
    logic signed [ACC_W-1:0] acc_re, acc_im, nxt_re, nxt_im;

    om_phase_accum #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (accept),
        .phase  (cnt_q[1:0]),
        .sample (in_sample),
        .acc_re (acc_re),
        .acc_im (acc_im),
        .nxt_re (nxt_re),
        .nxt_im (nxt_im)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        acc_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_clr = 1'b1;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                last     = in_valid && (cnt_q == CNT_LAST);
                if (last) begin
                    state_d = DONE;
                    // Result is taken from nxt_*, so the accumulator can be
                    // cleared on the same edge ready for the next segment.
                    acc_clr = 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = cont_q ? ACCUM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides every other event in the same cycle.
        if (abort) begin
            state_d = IDLE;
            acc_clr = 1'b1;
            accept  = 1'b0;
            last    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cont_q      <= 1'b0;
            out_valid_q <= 1'b0;
            xm_re       <= '0;
            xm_im       <= '0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                cnt_q       <= '0;
                cont_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            cnt_q  <= '0;
                            cont_q <= cfg_continuous;
                        end
                    end
                    ACCUM: begin
                        if (last) begin
                            cnt_q       <= '0;
                            xm_re       <= nxt_re;
                            xm_im       <= nxt_im;
                            out_valid_q <= 1'b1;
                        end else if (accept) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_om_segment_ctrl.sv
module tb_om_segment_ctrl;

    localparam int SEG   = 8;
    localparam int SEGK  = 1024;
    localparam int IN_W  = 25;
    localparam int ACC_W = 34;
    localparam longint SMAX = 64'd33554431;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic start, abort, cfg, in_valid, out_ready;
    logic [IN_W-1:0] in_sample;
    logic in_ready, out_valid, busy;
    logic signed [ACC_W-1:0] xm_re, xm_im;

    logic k_start, k_abort, k_cfg, k_in_valid, k_out_ready;
    logic [IN_W-1:0] k_sample;
    logic k_in_ready, k_out_valid, k_busy;
    logic signed [ACC_W-1:0] k_re, k_im;

    om_segment_ctrl #(.SEGMENT(SEG), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_continuous(cfg), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .xm_re(xm_re), .xm_im(xm_im), .busy(busy)
    );

    om_segment_ctrl #(.SEGMENT(SEGK), .IN_W(IN_W), .ACC_W(ACC_W)) dut_k (
        .clk(clk), .rst(rst), .start(k_start), .abort(k_abort),
        .cfg_continuous(k_cfg), .in_valid(k_in_valid), .in_sample(k_sample),
        .in_ready(k_in_ready), .out_valid(k_out_valid), .out_ready(k_out_ready),
        .xm_re(k_re), .xm_im(k_im), .busy(k_busy)
    );

    int ntot = 0, npass = 0, nfail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: segment phase (0 idle, 1 taking samples, 2 holding
    // result), the samples of the open segment, and the presented result.
    int     m_st;
    bit     m_cont, m_ov;
    longint m_re, m_im;
    longint q[$];
    int     naccept;
    int     cw[4] = '{1, 0, -1, 0};   // Re(e^(-j*pi*n/2))
    int     sw[4] = '{0, -1, 0, 1};   // Im(e^(-j*pi*n/2))

    task automatic seg_sum();
        m_re = 0;
        m_im = 0;
        for (int n = 0; n < q.size(); n++) begin
            m_re += q[n] * cw[n % 4];
            m_im += q[n] * sw[n % 4];
        end
    endtask

    task automatic cyc();
        chk("in_ready", in_ready, (m_st == 1) ? 1 : 0);
        if (rst) begin
            m_st = 0; m_ov = 0; m_cont = 0; m_re = 0; m_im = 0; q.delete();
        end else if (abort) begin
            m_st = 0; m_ov = 0; m_cont = 0; q.delete();
        end else begin
            case (m_st)
                0: if (start) begin q.delete(); m_cont = cfg; m_st = 1; end
                1: if (in_valid) begin
                    q.push_back(longint'(in_sample));
                    naccept++;
                    if (q.size() == SEG) begin
                        seg_sum();
                        m_ov = 1;
                        q.delete();
                        m_st = 2;
                    end
                end
                default: if (out_ready) begin m_ov = 0; m_st = m_cont ? 1 : 0; end
            endcase
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, (m_st != 0) ? 1 : 0);
        chk("xm_re", xm_re, m_re);
        chk("xm_im", xm_im, m_im);
    endtask

    task automatic run1k(input int ph, input longint exp_re, input longint exp_im);
        k_start = 1;
        @(posedge clk); #1;
        k_start = 0;
        chk("k_busy", k_busy, 1);
        for (int n = 0; n < SEGK; n++) begin
            chk("k_in_ready", k_in_ready, 1);
            chk("k_out_valid_early", k_out_valid, 0);
            k_in_valid = 1;
            k_sample = (n % 4 == ph) ? IN_W'(SMAX) : '0;
            @(posedge clk); #1;
        end
        k_in_valid = 0;
        chk("k_out_valid", k_out_valid, 1);
        chk("k_xm_re", k_re, exp_re);
        chk("k_xm_im", k_im, exp_im);
        @(posedge clk); #1;
        chk("k_out_valid_after", k_out_valid, 0);
        chk("k_busy_after", k_busy, 0);
        chk("k_xm_re_hold", k_re, exp_re);
    endtask

    int k, nres, stalls, budget;

    initial begin
        start = 0; abort = 0; cfg = 0; in_valid = 0; in_sample = '0; out_ready = 0;
        k_start = 0; k_abort = 0; k_cfg = 0; k_in_valid = 0; k_sample = '0; k_out_ready = 1;
        naccept = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        m_st = 0; m_ov = 0; m_cont = 0; m_re = 0; m_im = 0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xm_re", xm_re, 0);
        chk("rst_xm_im", xm_im, 0);
        chk("rst_k_busy", k_busy, 0);
        rst = 0;

        // Full-scale 1024-sample segments: largest magnitude without wrap.
        run1k(0, 64'sd8589934336, 0);
        run1k(1, 0, -64'sd8589934336);

        // Samples 1..8 in one-shot mode.
        out_ready = 1;
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= SEG; i++) begin
            in_valid = 1; in_sample = IN_W'(i); cyc();
        end
        in_valid = 0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_xm_re", xm_re, -4);
        chk("t1_xm_im", xm_im, 4);
        cyc();
        chk("t1_idle", busy, 0);

        // Constant 1000 with toggling valid, then hold the result 5 cycles.
        out_ready = 0;
        start = 1; cyc(); start = 0;
        naccept = 0;
        budget = 0;
        while (naccept < SEG && budget < 40) begin
            in_valid = (budget % 2 == 0); in_sample = IN_W'(1000);
            cyc();
            budget++;
        end
        chk("t2_accepts", naccept, SEG);
        chk("t2_xm_re", xm_re, 0);
        chk("t2_xm_im", xm_im, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_sample = IN_W'($urandom);
            cyc();
            chk("t4_hold_valid", out_valid, 1);
        end
        in_valid = 0; out_ready = 1; cyc();
        chk("t4_released", out_valid, 0);
        chk("t4_idle", busy, 0);

        // Continuous mode, samples 1..16.
        cfg = 1; start = 1; cyc(); start = 0; cfg = 0;
        k = 1; nres = 0; stalls = 0; budget = 0;
        while (k <= 2 * SEG && budget < 60) begin
            in_valid = 1; in_sample = IN_W'(k);
            if (m_st == 1) k++;
            else if (k > 1) stalls++;
            cyc();
            if (out_valid) begin
                nres++;
                chk("t5_xm_re", xm_re, -4);
                chk("t5_xm_im", xm_im, 4);
            end
            budget++;
        end
        in_valid = 0;
        chk("t5_all_taken", k, 2 * SEG + 1);
        chk("t5_nres", nres, 2);
        chk("t5_stall_le1", (stalls <= 1) ? 1 : 0, 1);
        cyc();
        chk("t5_rearmed", busy, 1);
        abort = 1; cyc(); abort = 0;
        chk("t5_abort_idle", busy, 0);

        // Abort after 5 samples, then a clean segment.
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= 5; i++) begin in_valid = 1; in_sample = IN_W'(100 * i); cyc(); end
        in_valid = 1; abort = 1; cyc(); abort = 0; in_valid = 0;
        chk("t6_abort_no_valid", out_valid, 0);
        out_ready = 0;
        start = 1; cyc(); start = 0;
        for (int i = 1; i <= SEG; i++) begin in_valid = 1; in_sample = IN_W'(i); cyc(); end
        in_valid = 0;
        chk("t6_xm_re", xm_re, -4);
        chk("t6_xm_im", xm_im, 4);
        rst = 1; cyc(); rst = 0;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_xm_re", xm_re, 0);
        chk("t6_rst_busy", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 5) == 0);
            cfg       = $urandom_range(0, 1);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sample = IN_W'($urandom);
            out_ready = $urandom_range(0, 1);
            cyc();
        end
        rst = 0; abort = 0; start = 0; in_valid = 0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
